aq_gemac_pause_tx_ctrl: RTL and testbench

Transmit-side PAUSE scheduler for the GbE MAC.
- Watches the Rx FIFO fill level against XOFF/XON watermarks.
- Requests the Tx MAC to emit 802.3x PAUSE frames carrying a quanta value.
- Refreshes XOFF before the advertised pause time expires.
- Sits between the Rx FIFO/CPU registers and the Tx MAC frame generator, in the Tx clock domain, alongside the receive-side pause flow control.

---
 rtl/aq_gemac_pkg.sv | 15 +
 rtl/aq_gemac_quanta_tick.sv | 29 ++
 rtl/aq_gemac_pause_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_aq_gemac_pause_tx_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_gemac_pkg.sv
// Shared types and constants for the GbE MAC PAUSE logic (Tx scheduler and Rx pause counter).
package aq_gemac_pkg;

  localparam int QUANTA_W        = 16;
  localparam int QUANTA_CLKS_DEF = 64;
  localparam logic [QUANTA_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XOFF_REQ  = 2'd1,
    ST_XOFF_HOLD = 2'd2,
    ST_XON_REQ   = 2'd3
  } pause_state_e;

endpackage

// File: rtl/aq_gemac_quanta_tick.sv
// Pause-quantum prescaler: counts 0..QUANTA_CLKS-1 while not cleared, pulses tick on wrap.
module aq_gemac_quanta_tick
  import aq_gemac_pkg::*;
#(
  parameter int QUANTA_CLKS = QUANTA_CLKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (QUANTA_CLKS > 1) ? $clog2(QUANTA_CLKS) : 1;

  logic [CW-1:0] count;

  assign tick = !clear && (count == CW'(QUANTA_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aq_gemac_pause_tx_ctrl.sv
// Tx PAUSE scheduler: raises XOFF/XON frame requests from Rx FIFO watermarks.
// Optional XON frame generation is enabled by defining AQ_GEMAC_PAUSE_XON_EN.
//
// state        | meaning
// ST_IDLE      | no remote pause in force, watching for XOFF condition
// ST_XOFF_REQ  | XOFF frame requested, waiting for Tx MAC ack
// ST_XOFF_HOLD | XOFF in force, refresh timer running
// ST_XON_REQ   | zero-quanta frame requested, waiting for Tx MAC ack
module aq_gemac_pause_tx_ctrl
  import aq_gemac_pkg::*;
#(
  parameter int FIFO_AW     = 11,
  parameter int QUANTA_CLKS = QUANTA_CLKS_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                PAUSE_TX_ENABLE,
  input  logic [FIFO_AW:0]    RX_FIFO_LEVEL,
  input  logic [FIFO_AW:0]    XOFF_THRESH,
  input  logic [FIFO_AW:0]    XON_THRESH,
  input  logic [QUANTA_W-1:0] PAUSE_TIME,
  input  logic [QUANTA_W-1:0] REFRESH_TIME,
  output logic                PAUSE_REQ,
  output logic [QUANTA_W-1:0] PAUSE_REQ_QUANTA,
  input  logic                PAUSE_ACK,
  output logic                XOFF_ACTIVE,
  output logic [QUANTA_W-1:0] PAUSE_FRAME_CNT
);

  pause_state_e        state, state_nxt;
  logic [QUANTA_W-1:0] quanta;
  logic [QUANTA_W-1:0] refresh_cnt;
  logic [QUANTA_W-1:0] frame_cnt;
  logic                xoff_active;
  logic                q_tick;
  logic                xoff_cond, xon_cond, exit_hold;
  logic                refresh_zero_next, refresh_expire, ack_taken;

  aq_gemac_quanta_tick #(
    .QUANTA_CLKS(QUANTA_CLKS)
  ) u_quanta_tick (
    .clk  (CLK),
    .rst  (RST),
    .clear(state != ST_XOFF_HOLD),
    .tick (q_tick)
  );

  assign xoff_cond = (RX_FIFO_LEVEL >= XOFF_THRESH);
  assign xon_cond  = (RX_FIFO_LEVEL < XON_THRESH);
  assign exit_hold = xon_cond || !PAUSE_TX_ENABLE;

  // Expire on the tick that brings the counter to zero so the re-send lands
  // exactly REFRESH_TIME quanta after the accepted XOFF.
  assign refresh_zero_next = (refresh_cnt == '0) || (q_tick && (refresh_cnt == QUANTA_W'(1)));
  assign refresh_expire    = (REFRESH_TIME != '0) && refresh_zero_next && xoff_cond;

  assign PAUSE_REQ        = (state == ST_XOFF_REQ) || (state == ST_XON_REQ);
  assign PAUSE_REQ_QUANTA = quanta;
  assign XOFF_ACTIVE      = xoff_active;
  assign PAUSE_FRAME_CNT  = frame_cnt;
  assign ack_taken        = PAUSE_ACK && PAUSE_REQ;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (PAUSE_TX_ENABLE && xoff_cond) state_nxt = ST_XOFF_REQ;
      end
      ST_XOFF_REQ: begin
        if (PAUSE_ACK) state_nxt = ST_XOFF_HOLD;
      end
      ST_XOFF_HOLD: begin
        if (exit_hold) begin
`ifdef AQ_GEMAC_PAUSE_XON_EN
          state_nxt = ST_XON_REQ;
`else
          state_nxt = ST_IDLE;
`endif
        end else if (refresh_expire) begin
          state_nxt = ST_XOFF_REQ;
        end
      end
      ST_XON_REQ: begin
`ifdef AQ_GEMAC_PAUSE_XON_EN
        if (PAUSE_ACK) state_nxt = ST_IDLE;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      quanta      <= '0;
      xoff_active <= 1'b0;
      refresh_cnt <= '0;
      frame_cnt   <= '0;
    end else begin
      state <= state_nxt;

      // Quanta is captured on entry so it stays frozen for the whole handshake.
      if ((state_nxt == ST_XOFF_REQ) && (state != ST_XOFF_REQ)) begin
        quanta <= PAUSE_TIME;
      end else if ((state_nxt == ST_XON_REQ) && (state != ST_XON_REQ)) begin
        quanta <= '0;
      end

      if ((state == ST_XOFF_REQ) && ack_taken) begin
        xoff_active <= 1'b1;
      end else if ((state == ST_XOFF_HOLD) &&
                   ((state_nxt == ST_IDLE) || (state_nxt == ST_XON_REQ))) begin
        xoff_active <= 1'b0;
      end

      if ((state == ST_XOFF_REQ) && ack_taken) begin
        refresh_cnt <= REFRESH_TIME;
      end else if (q_tick && (refresh_cnt != '0)) begin
        refresh_cnt <= refresh_cnt - QUANTA_W'(1);
      end

      if (ack_taken && (frame_cnt != CNT_MAX)) begin
        frame_cnt <= frame_cnt + QUANTA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aq_gemac_pause_tx_ctrl.sv
// Directed-random bench for aq_gemac_pause_tx_ctrl; follows AQ_GEMAC_PAUSE_XON_EN like the RTL.
module tb_aq_gemac_pause_tx_ctrl;

  localparam int FIFO_AW     = 11;
  localparam int QUANTA_CLKS = 64;

  logic              CLK;
  logic              RST;
  logic              PAUSE_TX_ENABLE;
  logic [FIFO_AW:0]  RX_FIFO_LEVEL;
  logic [FIFO_AW:0]  XOFF_THRESH;
  logic [FIFO_AW:0]  XON_THRESH;
  logic [15:0]       PAUSE_TIME;
  logic [15:0]       REFRESH_TIME;
  logic              PAUSE_REQ;
  logic [15:0]       PAUSE_REQ_QUANTA;
  logic              PAUSE_ACK;
  logic              XOFF_ACTIVE;
  logic [15:0]       PAUSE_FRAME_CNT;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  aq_gemac_pause_tx_ctrl #(
    .FIFO_AW    (FIFO_AW),
    .QUANTA_CLKS(QUANTA_CLKS)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .PAUSE_TX_ENABLE (PAUSE_TX_ENABLE),
    .RX_FIFO_LEVEL   (RX_FIFO_LEVEL),
    .XOFF_THRESH     (XOFF_THRESH),
    .XON_THRESH      (XON_THRESH),
    .PAUSE_TIME      (PAUSE_TIME),
    .REFRESH_TIME    (REFRESH_TIME),
    .PAUSE_REQ       (PAUSE_REQ),
    .PAUSE_REQ_QUANTA(PAUSE_REQ_QUANTA),
    .PAUSE_ACK       (PAUSE_ACK),
    .XOFF_ACTIVE     (XOFF_ACTIVE),
    .PAUSE_FRAME_CNT (PAUSE_FRAME_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_req(input string tag, input int budget, output int n);
    n = 0;
    while (!PAUSE_REQ && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check({tag, "_req"}, 32'(PAUSE_REQ), 1);
  endtask

  // Reference: every ack seen while a request is up counts one frame, saturating.
  task automatic send_ack(input string tag);
    logic was_req;
    was_req   = PAUSE_REQ;
    PAUSE_ACK = 1'b1;
    @(posedge CLK);
    #1;
    PAUSE_ACK = 1'b0;
    if (was_req && exp_cnt < 65535) exp_cnt++;
    check({tag, "_cnt"}, 32'(PAUSE_FRAME_CNT), 32'(exp_cnt));
  endtask

  task automatic frame(input string tag, input logic [15:0] exp_q);
    int n, d, bad;
    wait_req(tag, 50, n);
    check({tag, "_q"}, 32'(PAUSE_REQ_QUANTA), 32'(exp_q));
    d   = $urandom_range(0, 4);
    bad = 0;
    repeat (d) begin
      @(posedge CLK);
      #1;
      if (PAUSE_REQ !== 1'b1 || PAUSE_REQ_QUANTA !== exp_q) bad++;
    end
    check({tag, "_stable"}, 32'(bad), 0);
    send_ack(tag);
    check({tag, "_drop"}, 32'(PAUSE_REQ), 0);
  endtask

  initial begin
    logic [15:0]      pt, pt2, pt3;
    int               rt, n, bad, seen;
    logic [FIFO_AW:0] lvl_hi, lvl_lo;
    logic             xon_en;

`ifdef AQ_GEMAC_PAUSE_XON_EN
    xon_en = 1'b1;
`else
    xon_en = 1'b0;
`endif

    pt  = 16'($urandom_range(1, 65535));
    pt2 = 16'($urandom_range(1, 65535));
    pt3 = 16'($urandom_range(1, 65535));
    rt  = $urandom_range(1, 4);

    RST             = 1'b1;
    PAUSE_TX_ENABLE = 1'b0;
    RX_FIFO_LEVEL   = '0;
    XOFF_THRESH     = 12'(1500 + $urandom_range(0, 100));
    XON_THRESH      = 12'd500;
    PAUSE_TIME      = pt;
    REFRESH_TIME    = 16'(rt);
    PAUSE_ACK       = 1'b0;
    lvl_hi          = XOFF_THRESH + 12'($urandom_range(0, 300));
    lvl_lo          = 12'($urandom_range(0, 499));
    step(3);
    RST = 1'b0;
    step(1);

    check("rst_req",    32'(PAUSE_REQ), 0);
    check("rst_quanta", 32'(PAUSE_REQ_QUANTA), 0);
    check("rst_xoff",   32'(XOFF_ACTIVE), 0);
    check("rst_cnt",    32'(PAUSE_FRAME_CNT), 0);

    // First XOFF: one cycle after the level crosses the watermark.
    PAUSE_TX_ENABLE = 1'b1;
    RX_FIFO_LEVEL   = lvl_hi;
    wait_req("a_xoff", 5, n);
    check("a_lat", 32'(n), 1);
    check("a_q", 32'(PAUSE_REQ_QUANTA), 32'(pt));
    step(2);
    check("a_hold_req", 32'(PAUSE_REQ), 1);
    send_ack("a");
    check("a_drop", 32'(PAUSE_REQ), 0);
    check("a_xoff_act", 32'(XOFF_ACTIVE), 1);

    // Refresh re-send after REFRESH_TIME quanta; quanta relatched on re-entry.
    PAUSE_TIME = pt2;
    n = 0;
    while (!PAUSE_REQ && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("b_refresh_dly", 32'(n), 32'(rt * QUANTA_CLKS));
    check("b_q", 32'(PAUSE_REQ_QUANTA), 32'(pt2));
    check("b_xoff_act", 32'(XOFF_ACTIVE), 1);
    PAUSE_TIME   = pt3;
    REFRESH_TIME = 16'd0;
    step(2);
    check("b_q_frozen", 32'(PAUSE_REQ_QUANTA), 32'(pt2));
    send_ack("b");

    // Refresh disabled: no further request while the level stays high.
    seen = 0;
    repeat (600) begin
      @(posedge CLK);
      #1;
      if (PAUSE_REQ) seen++;
    end
    check("b_no_refresh", 32'(seen), 0);
    check("b_still_xoff", 32'(XOFF_ACTIVE), 1);

    // Level falls below XON watermark.
    RX_FIFO_LEVEL = lvl_lo;
    if (xon_en) begin
      frame("c_xon", 16'h0000);
      check("c_xoff_act", 32'(XOFF_ACTIVE), 0);
    end else begin
      step(1);
      check("c_xoff_act", 32'(XOFF_ACTIVE), 0);
      seen = 0;
      repeat (5) begin
        @(posedge CLK);
        #1;
        if (PAUSE_REQ) seen++;
      end
      check("c_no_req", 32'(seen), 0);
    end

    // Enable dropped mid-request: request must not be withdrawn.
    PAUSE_TIME    = pt;
    RX_FIFO_LEVEL = lvl_hi;
    wait_req("d_xoff", 5, n);
    PAUSE_TX_ENABLE = 1'b0;
    RX_FIFO_LEVEL   = lvl_lo;
    bad = 0;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (PAUSE_REQ !== 1'b1 || PAUSE_REQ_QUANTA !== pt) bad++;
    end
    check("d_stable", 32'(bad), 0);
    send_ack("d");
    check("d_hold_xoff", 32'(XOFF_ACTIVE), 1);
    if (xon_en) begin
      frame("d_xon", 16'h0000);
    end else begin
      step(1);
      check("d_idle_req", 32'(PAUSE_REQ), 0);
    end
    check("d_xoff_clr", 32'(XOFF_ACTIVE), 0);

    // Spurious ack while idle is ignored.
    step(2);
    send_ack("e_spurious");
    check("e_req", 32'(PAUSE_REQ), 0);
    check("e_xoff", 32'(XOFF_ACTIVE), 0);

    // Reset in the middle of a quantum during XOFF hold.
    REFRESH_TIME    = 16'd3;
    PAUSE_TX_ENABLE = 1'b1;
    RX_FIFO_LEVEL   = lvl_hi;
    frame("f_xoff", pt);
    step(30);
    RST = 1'b1;
    step(1);
    exp_cnt = 0;
    check("f_rst_req",    32'(PAUSE_REQ), 0);
    check("f_rst_quanta", 32'(PAUSE_REQ_QUANTA), 0);
    check("f_rst_xoff",   32'(XOFF_ACTIVE), 0);
    check("f_rst_cnt",    32'(PAUSE_FRAME_CNT), 0);
    RST = 1'b0;
    step(1);
    check("f_fresh_req", 32'(PAUSE_REQ), 1);
    frame("f_fresh", pt);

    // Saturation with misconfigured thresholds producing back-to-back frames.
    RX_FIFO_LEVEL = lvl_lo;
    if (xon_en) frame("g_xon", 16'h0000);
    step(3);
    force dut.frame_cnt = 16'hFFFE;
    #1;
    release dut.frame_cnt;
    #1;
    exp_cnt = 65534;
    check("g_preload", 32'(PAUSE_FRAME_CNT), 32'(exp_cnt));
    REFRESH_TIME  = 16'd0;
    XOFF_THRESH   = 12'd400;
    XON_THRESH    = 12'd600;
    RX_FIFO_LEVEL = 12'd500;
    for (int i = 0; i < 4; i++) begin
      frame("g_alt", (xon_en && (i % 2 == 1)) ? 16'h0000 : pt);
    end
    check("g_sat", 32'(PAUSE_FRAME_CNT), 32'hFFFF);

    PAUSE_TX_ENABLE = 1'b0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
